// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, MEM-stage access state and
// the pipeline control word whose all-zero value is the bubble (NOP).
package lc3b_types;

  localparam int unsigned REG_W    = 3;
  localparam int unsigned OPCODE_W = 4;

  typedef logic [REG_W-1:0] lc3b_reg;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_IND2 = 1'b1
  } lc3b_memstate_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                indirect;
    logic                branch;
    logic [1:0]          aluop;
    logic [1:0]          wbsel;
  } lc3b_ctrl_t;

  // Zeroed control word: no writeback, no memory access, no branch.
  localparam lc3b_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: EX-stage load whose destination feeds an ID-stage
// source that forwarding cannot reach in time.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    idex_memread_i,
  input  logic    idex_regwrite_i,
  input  lc3b_reg idex_dest_i,
  input  lc3b_reg ifid_src1_i,
  input  lc3b_reg ifid_src2_i,
  input  logic    ifid_use_src1_i,
  input  logic    ifid_use_src2_i,
  output logic    load_use_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit   = ifid_use_src1_i & (ifid_src1_i == idex_dest_i);
  assign src2_hit   = ifid_use_src2_i & (ifid_src2_i == idex_dest_i);
  assign load_use_o = idex_memread_i & idex_regwrite_i & (src1_hit | src2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline: pipeline register
// enables, bubble strobes, PC redirect and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 icache_req,
  input  logic                 icache_resp,
  input  logic                 dcache_req,
  input  logic                 dcache_resp,
  input  logic                 mem_indirect,
  input  logic                 br_taken,
  input  logic                 idex_memread,
  input  logic                 idex_regwrite,
  input  lc3b_reg              idex_dest,
  input  lc3b_reg              ifid_src1,
  input  lc3b_reg              ifid_src2,
  input  logic                 ifid_use_src1,
  input  logic                 ifid_use_src2,
  input  logic                 cnt_clear,
  output logic                 pc_load,
  output logic                 ifid_load,
  output logic                 idex_load,
  output logic                 exmem_load,
  output logic                 memwb_load,
  output logic                 ifid_bubble,
  output logic                 idex_bubble,
  output logic                 exmem_bubble,
  output logic                 pcmux_sel,
  output logic                 indirect_phase,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  lc3b_memstate_t       state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;

  logic load_use;
  logic resp_v;
  logic mem_done;
  logic mem_stall;
  logic fetch_stall;
  logic redirect;

  hazard_detect u_hazard_detect (
    .idex_memread_i  (idex_memread),
    .idex_regwrite_i (idex_regwrite),
    .idex_dest_i     (idex_dest),
    .ifid_src1_i     (ifid_src1),
    .ifid_src2_i     (ifid_src2),
    .ifid_use_src1_i (ifid_use_src1),
    .ifid_use_src2_i (ifid_use_src2),
    .load_use_o      (load_use)
  );

  // A response with no request in flight is stray and must not move the FSM.
  assign resp_v      = dcache_req & dcache_resp;
  assign mem_done    = resp_v & (~mem_indirect | (state_q == M_IND2));
  assign mem_stall   = dcache_req & ~mem_done;
  assign fetch_stall = icache_req & ~icache_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= M_IDLE;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // LDI/STI sequencing: remember that the pointer access has returned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE: if (resp_v && mem_indirect) state_d = M_IND2;
      M_IND2: if (resp_v)                 state_d = M_IDLE;
    endcase
  end

  // Priority chain: freeze, redirect, load-use bubble, fetch wait, normal.
  always_comb begin
    pc_load        = 1'b0;
    ifid_load      = 1'b0;
    idex_load      = 1'b0;
    exmem_load     = 1'b0;
    memwb_load     = 1'b0;
    ifid_bubble    = 1'b0;
    idex_bubble    = 1'b0;
    exmem_bubble   = 1'b0;
    pcmux_sel      = 1'b0;
    redirect       = 1'b0;
    indirect_phase = reset_n & (state_q == M_IND2);
    if (reset_n) begin
      if (mem_stall || (br_taken && fetch_stall)) begin
        pc_load = 1'b0;
      end else if (br_taken) begin
        redirect     = 1'b1;
        pc_load      = 1'b1;
        pcmux_sel    = 1'b1;
        ifid_load    = 1'b1;
        idex_load    = 1'b1;
        exmem_load   = 1'b1;
        memwb_load   = 1'b1;
        ifid_bubble  = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
      end else if (load_use) begin
        idex_load   = 1'b1;
        idex_bubble = 1'b1;
        exmem_load  = 1'b1;
        memwb_load  = 1'b1;
      end else if (fetch_stall) begin
        ifid_load   = 1'b1;
        ifid_bubble = 1'b1;
        idex_load   = 1'b1;
        exmem_load  = 1'b1;
        memwb_load  = 1'b1;
      end else begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        idex_load  = 1'b1;
        exmem_load = 1'b1;
        memwb_load = 1'b1;
      end
    end
  end

  // Saturating performance counters; clear beats increment.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_load && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_WIDTH'(1);
      if (redirect && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_WIDTH'(1);
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a
// priority-rule reference model.
module tb_pipeline_hazard_ctrl;
  import lc3b_types::*;

  localparam int unsigned CW      = 16;
  localparam int unsigned CNT_TOP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          icache_req, icache_resp, dcache_req, dcache_resp;
  logic          mem_indirect, br_taken, idex_memread, idex_regwrite;
  lc3b_reg       idex_dest, ifid_src1, ifid_src2;
  logic          ifid_use_src1, ifid_use_src2, cnt_clear;
  logic          pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic          ifid_bubble, idex_bubble, exmem_bubble, pcmux_sel, indirect_phase;
  logic [CW-1:0] stall_count, flush_count;
  logic [9:0]    obs_vec;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_req(icache_req), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .mem_indirect(mem_indirect), .br_taken(br_taken),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_dest(idex_dest), .ifid_src1(ifid_src1), .ifid_src2(ifid_src2),
    .ifid_use_src1(ifid_use_src1), .ifid_use_src2(ifid_use_src2),
    .cnt_clear(cnt_clear),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .pcmux_sel(pcmux_sel),
    .indirect_phase(indirect_phase),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  assign obs_vec = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                    ifid_bubble, idex_bubble, exmem_bubble, pcmux_sel, indirect_phase};

  int          checks = 0;
  int          errors = 0;
  // Model: responses already seen for the current indirect op, plus counters.
  int          m_resps_seen;
  int unsigned m_stall, m_flush;
  logic [9:0]  e_ctrl;
  logic        e_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval();
    logic resp, done, ms, fs, lu;
    resp = dcache_req && dcache_resp;
    done = resp && (!mem_indirect || m_resps_seen == 1);
    ms   = dcache_req && !done;
    fs   = icache_req && !icache_resp;
    lu   = idex_memread && idex_regwrite &&
           ((ifid_use_src1 && ifid_src1 == idex_dest) ||
            (ifid_use_src2 && ifid_src2 == idex_dest));
    e_redir = 1'b0;
    if (!reset_n)                  e_ctrl = 10'b00000_000_0_0;
    else if (ms || (br_taken && fs)) e_ctrl = 10'b00000_000_0_0;
    else if (br_taken) begin
      e_ctrl  = 10'b11111_111_1_0;
      e_redir = 1'b1;
    end
    else if (lu)                   e_ctrl = 10'b00111_010_0_0;
    else if (fs)                   e_ctrl = 10'b01111_100_0_0;
    else                           e_ctrl = 10'b11111_000_0_0;
    e_ctrl[0] = reset_n && (m_resps_seen == 1);
  endtask

  task automatic model_update();
    if (!reset_n) begin
      m_resps_seen = 0;
      m_stall      = 0;
      m_flush      = 0;
    end else begin
      if (dcache_req && dcache_resp) begin
        if (m_resps_seen == 1)  m_resps_seen = 0;
        else if (mem_indirect)  m_resps_seen = 1;
      end
      if (cnt_clear) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!e_ctrl[9] && m_stall < CNT_TOP) m_stall++;
        if (e_redir && m_flush < CNT_TOP)    m_flush++;
      end
    end
  endtask

  // Let combinational outputs settle mid-cycle, compare with the model.
  task automatic settle();
    #2;
    if (!reset_n) begin
      m_resps_seen = 0;
      m_stall      = 0;
      m_flush      = 0;
    end
    model_eval();
    chk("ctrl", 32'(obs_vec), 32'(e_ctrl));
    chk("stall_cnt", 32'(stall_count), m_stall);
    chk("flush_cnt", 32'(flush_count), m_flush);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    icache_req = 0; icache_resp = 0; dcache_req = 0; dcache_resp = 0;
    mem_indirect = 0; br_taken = 0; idex_memread = 0; idex_regwrite = 0;
    idex_dest = '0; ifid_src1 = '0; ifid_src2 = '0;
    ifid_use_src1 = 0; ifid_use_src2 = 0; cnt_clear = 0;
  endtask

  initial begin
    m_resps_seen = 0; m_stall = 0; m_flush = 0;
    idle_inputs();
    reset_n = 1'b0;
    settle();
    chk("reset_ctrl", 32'(obs_vec), 32'h0);
    advance();
    reset_n = 1'b1;

    // Load R1 in EX, ID reads R1 through src2.
    idex_memread = 1; idex_regwrite = 1; idex_dest = 3'd1;
    ifid_src1 = 3'd3; ifid_src2 = 3'd1; ifid_use_src2 = 1;
    settle();
    chk("lu_pc_load", 32'(pc_load), 32'h0);
    chk("lu_idex_bubble", 32'(idex_bubble), 32'h1);
    advance();
    idle_inputs();
    settle();
    chk("lu_stall_cnt", 32'(stall_count), 32'h1);
    chk("lu_recover", 32'(pc_load), 32'h1);
    advance();

    // LDI with responses on cycles 3 and 6.
    for (int c = 0; c <= 6; c++) begin
      dcache_req = 1; mem_indirect = 1;
      dcache_resp = (c == 3 || c == 6);
      settle();
      chk("ldi_phase", 32'(indirect_phase), 32'(c >= 4));
      chk("ldi_memwb_load", 32'(memwb_load), 32'(c == 6));
      advance();
    end
    idle_inputs();
    settle();
    chk("ldi_idle", 32'(indirect_phase), 32'h0);
    advance();

    // Clean redirect, then a redirect held off by a fetch wait.
    br_taken = 1;
    settle();
    chk("br_pcmux", 32'(pcmux_sel), 32'h1);
    chk("br_bubbles", 32'({ifid_bubble, idex_bubble, exmem_bubble}), 32'h7);
    advance();
    br_taken = 0;
    settle();
    chk("br_flush_cnt", 32'(flush_count), 32'h1);
    advance();
    br_taken = 1; icache_req = 1;
    for (int c = 0; c < 3; c++) begin
      icache_resp = (c == 2);
      settle();
      chk("br_fw_pcmux", 32'(pcmux_sel), 32'(c == 2));
      advance();
    end
    idle_inputs();

    // Saturate the stall counter with fetch waits, then clear it.
    cnt_clear = 1;
    settle();
    advance();
    cnt_clear = 0; icache_req = 1; icache_resp = 0;
    for (int c = 0; c < (1 << CW) + 5; c++) begin
      settle();
      advance();
    end
    chk("sat_stall", 32'(stall_count), 32'hFFFF);
    icache_req = 0; cnt_clear = 1;
    settle();
    advance();
    cnt_clear = 0;
    settle();
    chk("clr_stall", 32'(stall_count), 32'h0);
    advance();

    // Reset asserted while the second indirect access is outstanding.
    dcache_req = 1; mem_indirect = 1; dcache_resp = 1;
    settle();
    advance();
    dcache_resp = 0;
    settle();
    chk("ind2_phase", 32'(indirect_phase), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'(obs_vec), 32'h0);
    chk("rst_async_cnt", 32'({stall_count, flush_count}), 32'h0);
    advance();
    reset_n = 1'b1;
    settle();
    chk("rst_release_phase", 32'(indirect_phase), 32'h0);
    advance();
    idle_inputs();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      icache_req    = $urandom_range(0, 99) < 50;
      icache_resp   = $urandom_range(0, 99) < 50;
      dcache_req    = $urandom_range(0, 99) < 35;
      dcache_resp   = $urandom_range(0, 99) < 45;
      mem_indirect  = $urandom_range(0, 99) < 35;
      br_taken      = $urandom_range(0, 99) < 15;
      idex_memread  = $urandom_range(0, 99) < 40;
      idex_regwrite = $urandom_range(0, 99) < 70;
      idex_dest     = 3'($urandom_range(0, 3));
      ifid_src1     = 3'($urandom_range(0, 3));
      ifid_src2     = 3'($urandom_range(0, 3));
      ifid_use_src1 = $urandom_range(0, 99) < 70;
      ifid_use_src2 = $urandom_range(0, 99) < 70;
      cnt_clear     = $urandom_range(0, 99) < 2;
      reset_n       = $urandom_range(0, 99) >= 1;
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage LC-3b pipeline. It observes the fetch, execute and memory stages, then drives every pipeline-register load enable, the bubble/flush strobes and the PC redirect select. It detects load-use hazards that forwarding cannot cover, memory and fetch wait states, two-access indirect operations (LDI/STI) and taken-branch redirects. It also keeps saturating performance counters for stall and flush cycles.

## Interface
Parameters:
- CNT_WIDTH, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- icache_req  in  1  fetch access outstanding this cycle
- icache_resp  in  1  fetch access completes this cycle
- dcache_req  in  1  MEM-stage instruction accesses memory
- dcache_resp  in  1  data access completes this cycle
- mem_indirect  in  1  MEM-stage instruction is LDI/STI (two data accesses)
- br_taken  in  1  control transfer resolved taken in MEM
- idex_memread  in  1  EX-stage instruction is a load
- idex_regwrite  in  1  EX-stage instruction writes a register
- idex_dest  in  lc3b_reg  EX-stage destination
- ifid_src1, ifid_src2  in  lc3b_reg  ID-stage sources
- ifid_use_src1, ifid_use_src2  in  1  ID-stage source actually read
- cnt_clear  in  1  synchronous clear of both counters
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1  register enables
- ifid_bubble, idex_bubble, exmem_bubble  out  1  load a NOP (control word zeroed) instead of upstream data
- pcmux_sel  out  1  0 = PC+2, 1 = branch target
- indirect_phase  out  1  0 = first (pointer) access, 1 = second access
- stall_count, flush_count  out  CNT_WIDTH  saturating counters

## Operation
- MEM FSM states: M_IDLE, M_IND2.
  - M_IDLE → M_IND2 on dcache_resp & mem_indirect.
  - M_IND2 → M_IDLE on dcache_resp.
  - indirect_phase = (state == M_IND2).
- mem_done = dcache_resp & (!mem_indirect | state == M_IND2).
- mem_stall = dcache_req & !mem_done.
- fetch_stall = icache_req & !icache_resp.
- load_use = idex_memread & idex_regwrite & ((ifid_use_src1 & ifid_src1 == idex_dest) | (ifid_use_src2 & ifid_src2 == idex_dest)).
- Priority (first match wins):
  1. **Freeze:** mem_stall, or br_taken & fetch_stall. All loads 0, all bubbles 0, pcmux_sel 0.
  2. **Redirect:** br_taken. pc_load = 1, pcmux_sel = 1, all register loads 1, ifid_bubble = idex_bubble = exmem_bubble = 1. The branch itself advances into MEM/WB.
  3. **Load-use:** pc_load = 0, ifid_load = 0, idex_load = 1 with idex_bubble = 1; exmem and memwb load 1.
  4. **Fetch wait:** fetch_stall. pc_load = 0, ifid_load = 1 with ifid_bubble = 1; downstream loads 1.
  5. **Normal:** all loads 1, bubbles 0, pcmux_sel 0.
- Counters:
  - stall_count increments in any cycle in which pc_load = 0.
  - flush_count increments on each redirect.
  - Both saturate at all-ones.
  - cnt_clear has priority over increment.

## Timing
- All control outputs are combinational (same cycle) from inputs and FSM state. FSM and counters update on posedge clk.
- While reset_n is low, regardless of clk:
  - state = M_IDLE, counters = 0.
  - All load enables and bubbles are forced 0, pcmux_sel = 0, indirect_phase = 0.
- Reset deasserting mid-access: the FSM restarts in M_IDLE. Upstream aborts the outstanding access.
- Load-use costs exactly one bubble cycle. The next cycle the load is in MEM, and forwarding covers it.
- Indirect access: the pipeline stays frozen across both accesses. It advances only in the cycle of the second dcache_resp.
- br_taken together with load_use: redirect wins, and the hazard instruction is flushed.
- dcache_resp without dcache_req: ignored, no state change.

## Structure
- In lc3b_types:
  - typedef lc3b_memstate_t (M_IDLE, M_IND2).
  - constant for the NOP control word used by bubbles.
- One sub-module: hazard_detect, the combinational load_use compare. Everything else, including the FSM, priority logic and counters, lives in the top level.

## Test plan
- Load R1 in EX, ID reads R1 via src2 with ifid_use_src2 = 1 → one cycle with pc_load = 0, idex_bubble = 1; stall_count 0 → 1; normal next cycle.
- LDI with dcache_resp on cycles 3 and 6 → freeze cycles 0–5; indirect_phase = 1 on cycles 4–6; all loads 1 on cycle 6; FSM back to M_IDLE.
- br_taken with no stalls → pcmux_sel = 1, three bubbles asserted, flush_count = 1. Same with icache_req & !icache_resp → freeze until icache_resp, then redirect.
- Drive 2^CNT_WIDTH + 5 fetch-wait cycles → stall_count holds 0xFFFF. cnt_clear → 0 next edge.
- Assert reset_n low in M_IND2 mid-access → outputs 0 immediately; after release state = M_IDLE, indirect_phase = 0.
